// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline control decoder: opcodes, ALU op codes,
// control-word bit positions and the output buffer state encoding.
package pipe_ctrl_pkg;

  localparam int CTRL_WIDTH = 12;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SRA = 4'b1101;
  localparam logic [3:0] ALU_OR  = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0111;
  localparam logic [3:0] ALU_BEQ = 4'b1000;
  localparam logic [3:0] ALU_BNE = 4'b1001;

  localparam int CTRL_JAL       = 11;
  localparam int CTRL_JALR      = 10;
  localparam int CTRL_BRANCH    = 9;
  localparam int CTRL_MEM_TO_REG = 8;
  localparam int CTRL_MEM_WRITE = 7;
  localparam int CTRL_MEM_READ  = 6;
  localparam int CTRL_REG_WRITE = 5;
  localparam int CTRL_ALU_SRC   = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_e;

  function automatic logic [CTRL_WIDTH-1:0] ctrl_flag(input int idx);
    logic [CTRL_WIDTH-1:0] flag;
    flag = '0;
    flag[idx] = 1'b1;
    return flag;
  endfunction

endpackage

// File: rtl/ctrl_imm_decode.sv
// Combinational RISC-V instruction to control word / immediate / illegal flag.
// DECODE_ILLEGAL_TRAP_EN enables reporting of unrecognised words on illegal.
module ctrl_imm_decode
  import pipe_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]           instr,
  output logic [CTRL_WIDTH-1:0] ctrl,
  output logic [XLEN-1:0]       imm,
  output logic                  illegal
);

  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [6:0]            funct7;
  logic [6:0]            shift_fn;
  logic [31:0]           shamt;
  logic [31:0]           imm_i;
  logic [31:0]           imm_s;
  logic [31:0]           imm_b;
  logic [31:0]           imm_j;
  logic [31:0]           imm32;
  logic [CTRL_WIDTH-1:0] ctrl_raw;
  logic                  known;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // RV64 shifts carry a 6-bit shamt, so bit 25 belongs to shamt, not funct7.
  assign shift_fn = (XLEN == 64) ? {instr[31:26], 1'b0} : instr[31:25];
  assign shamt    = (XLEN == 64) ? {26'b0, instr[25:20]} : {27'b0, instr[24:20]};

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    ctrl_raw = '0;
    imm32    = '0;
    known    = 1'b0;
    case (opcode)
      OPC_OP: begin
        ctrl_raw = ctrl_flag(CTRL_REG_WRITE);
        if (funct7 == 7'b0000000) begin
          known = 1'b1;
          case (funct3)
            3'b000:  ctrl_raw[3:0] = ALU_ADD;
            3'b001:  ctrl_raw[3:0] = ALU_SLL;
            3'b010:  ctrl_raw[3:0] = ALU_SLT;
            3'b100:  ctrl_raw[3:0] = ALU_XOR;
            3'b101:  ctrl_raw[3:0] = ALU_SRL;
            3'b110:  ctrl_raw[3:0] = ALU_OR;
            3'b111:  ctrl_raw[3:0] = ALU_AND;
            default: known = 1'b0;
          endcase
        end else if (funct7 == 7'b0100000) begin
          known = 1'b1;
          case (funct3)
            3'b000:  ctrl_raw[3:0] = ALU_SUB;
            3'b101:  ctrl_raw[3:0] = ALU_SRA;
            default: known = 1'b0;
          endcase
        end
      end
      OPC_OP_IMM: begin
        ctrl_raw = ctrl_flag(CTRL_REG_WRITE) | ctrl_flag(CTRL_ALU_SRC);
        imm32    = imm_i;
        known    = 1'b1;
        case (funct3)
          3'b000: ctrl_raw[3:0] = ALU_ADD;
          3'b010: ctrl_raw[3:0] = ALU_SLT;
          3'b100: ctrl_raw[3:0] = ALU_XOR;
          3'b110: ctrl_raw[3:0] = ALU_OR;
          3'b111: ctrl_raw[3:0] = ALU_AND;
          3'b001: begin
            ctrl_raw[3:0] = ALU_SLL;
            imm32         = shamt;
            known         = (shift_fn == 7'b0000000);
          end
          3'b101: begin
            ctrl_raw[3:0] = (shift_fn == 7'b0100000) ? ALU_SRA : ALU_SRL;
            imm32         = shamt;
            known         = (shift_fn == 7'b0000000) || (shift_fn == 7'b0100000);
          end
          default: known = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        ctrl_raw = ctrl_flag(CTRL_REG_WRITE) | ctrl_flag(CTRL_ALU_SRC)
                 | ctrl_flag(CTRL_MEM_READ) | ctrl_flag(CTRL_MEM_TO_REG);
        imm32    = imm_i;
        known    = 1'b1;
      end
      OPC_STORE: begin
        ctrl_raw = ctrl_flag(CTRL_MEM_WRITE) | ctrl_flag(CTRL_ALU_SRC);
        imm32    = imm_s;
        known    = (funct3[2] == 1'b0);
      end
      OPC_BRANCH: begin
        ctrl_raw = ctrl_flag(CTRL_BRANCH);
        imm32    = imm_b;
        known    = 1'b1;
        case (funct3)
          3'b000:  ctrl_raw[3:0] = ALU_BEQ;
          3'b001:  ctrl_raw[3:0] = ALU_BNE;
          default: known = 1'b0;
        endcase
      end
      OPC_JALR: begin
        ctrl_raw = ctrl_flag(CTRL_JALR) | ctrl_flag(CTRL_REG_WRITE) | ctrl_flag(CTRL_ALU_SRC);
        imm32    = imm_i;
        known    = (funct3 == 3'b000);
      end
      OPC_JAL: begin
        ctrl_raw = ctrl_flag(CTRL_JAL) | ctrl_flag(CTRL_REG_WRITE);
        imm32    = imm_j;
        known    = 1'b1;
      end
      default: known = 1'b0;
    endcase
  end

  // Unrecognised words always decode to an all-zero entry (a harmless bubble).
  assign ctrl = known ? ctrl_raw : '0;
  assign imm  = known ? XLEN'($signed(imm32)) : '0;

`ifdef DECODE_ILLEGAL_TRAP_EN
  assign illegal = !known;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: rtl/pipe_ctrl_decoder.sv
// Decode stage with a 2-entry skid buffer; head entry drives the outputs.
// Optional DECODE_ILLEGAL_TRAP_EN flags unrecognised instructions on illegal.
module pipe_ctrl_decoder
  import pipe_ctrl_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ctrl_signal,
  output logic [XLEN-1:0]   immediate,
  output logic              illegal
);

  // Handshake: a transfer happens on a rising edge where valid && ready;
  // in_ready/out_valid depend only on the registered buffer state.
  buf_state_e        state;
  logic [CTRL_W-1:0] dec_ctrl;
  logic [XLEN-1:0]   dec_imm;
  logic              dec_illegal;
  logic [CTRL_W-1:0] tail_ctrl;
  logic [XLEN-1:0]   tail_imm;
  logic              tail_illegal;
  logic              push;
  logic              pop;

  ctrl_imm_decode #(
    .XLEN (XLEN)
  ) u_decode (
    .instr   (in_instr),
    .ctrl    (dec_ctrl),
    .imm     (dec_imm),
    .illegal (dec_illegal)
  );

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= EMPTY;
      ctrl_signal  <= '0;
      immediate    <= '0;
      illegal      <= 1'b0;
      tail_ctrl    <= '0;
      tail_imm     <= '0;
      tail_illegal <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            ctrl_signal <= dec_ctrl;
            immediate   <= dec_imm;
            illegal     <= dec_illegal;
            state       <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            ctrl_signal <= dec_ctrl;
            immediate   <= dec_imm;
            illegal     <= dec_illegal;
          end else if (push) begin
            tail_ctrl    <= dec_ctrl;
            tail_imm     <= dec_imm;
            tail_illegal <= dec_illegal;
            state        <= FULL;
          end else if (pop) begin
            // Head outputs read as zero whenever the buffer is empty.
            ctrl_signal <= '0;
            immediate   <= '0;
            illegal     <= 1'b0;
            state       <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            ctrl_signal <= tail_ctrl;
            immediate   <= tail_imm;
            illegal     <= tail_illegal;
            state       <= ONE;
          end
        end
        default: begin
          ctrl_signal <= '0;
          immediate   <= '0;
          illegal     <= 1'b0;
          state       <= EMPTY;
        end
      endcase
    end
  end

endmodule

// File: doc/pipe_ctrl_decoder.md
PIPE_CTRL_DECODER -- requirements
Module: pipe_ctrl_decoder

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath/immediate width; legal values 32 and 64 only.
REQ-002 SHALL have parameter CTRL_W, default 12, control word width; fixed at 12.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  instruction word present.
REQ-006 SHALL have port in_ready  output  1  decoder can accept a word this cycle.
REQ-007 SHALL have port in_instr  input  32  raw RISC-V instruction.
REQ-008 SHALL have port out_valid  output  1  decoded entry at buffer head.
REQ-009 SHALL have port out_ready  input  1  consumer takes head entry.
REQ-010 SHALL have port ctrl_signal  output  CTRL_W  head control word.
REQ-011 SHALL have port immediate  output  XLEN  head sign-extended immediate.
REQ-012 SHALL have port illegal  output  1  head instruction not recognised.

Function
REQ-013 SHALL map ctrl_signal as: [11] jal, [10] jalr, [9] branch, [8] mem-to-reg, [7] mem write, [6] mem read, [5] reg write, [4] ALU src imm, [3:0] ALU op.
REQ-014 SHALL use ALU ops: add 0000, sub 1000, sll 0001, slt 0010, xor 0100, srl 0101, sra 1101, or 0110, and 0111; beq 1000, bne 1001.
REQ-015 SHALL decode R (reg write), OP-IMM (reg write, ALU src), load (any funct3: reg write, ALU src, mem read, mem-to-reg, add), store (mem write, ALU src, add), beq/bne (branch), jalr (jalr, reg write, ALU src), jal (jal, reg write).
REQ-016 SHALL sign-extend I/S/B/J immediates from bit 31 to XLEN; B and J have bit 0 zero; R-type immediate is 0.
REQ-017 SHALL, when XLEN=64, take shamt from in_instr[25:20]; when XLEN=32, from in_instr[24:20].
REQ-018 SHALL hold decoded entries in a 2-entry buffer with states EMPTY, ONE, FULL.
REQ-019 SHALL drive in_ready = (state != FULL); SHALL drive out_valid = (state != EMPTY).
REQ-020 SHALL capture in_instr on in_valid && in_ready; latency 1 cycle from accept to out_valid.
REQ-021 SHALL pop head on out_valid && out_ready; simultaneous push and pop in ONE leaves state ONE with the new entry at the head; EMPTY+push -> ONE; ONE+push only -> FULL; FULL+pop -> ONE; ONE+pop only -> EMPTY.
REQ-022 SHALL keep head outputs stable while out_valid && !out_ready.
REQ-023 SHALL preserve order; no entry dropped or duplicated.
REQ-024 SHALL drive ctrl_signal, immediate, illegal to 0 whenever state is EMPTY.

Reset
REQ-025 SHALL, on rising clk with rst_n=0, set state EMPTY, out_valid 0, ctrl_signal 0, immediate 0, illegal 0.
REQ-026 SHALL discard all buffered entries on reset mid-operation; in_ready is 1 the first cycle after reset.

Configuration
REQ-027 SHALL, with DECODE_ILLEGAL_TRAP_EN defined, set illegal=1 with ctrl_signal=0 and immediate=0 for an unrecognised opcode/funct3/funct7.
REQ-028 SHALL, without DECODE_ILLEGAL_TRAP_EN, tie illegal to 0 and decode unrecognised words to ctrl_signal=0, immediate=0.

Structure
REQ-029 SHALL place opcode constants, ALU op codes, control bit indices and the state enum in shared package pipe_ctrl_pkg.
REQ-030 SHALL use sub-module ctrl_imm_decode (pure combinational instruction-to-ctrl/imm/illegal) feeding the buffer.

Verification
REQ-031 SHALL cover: add x1,x2,x3 (0x003100B3), out_ready=1 -> next cycle out_valid=1, ctrl_signal=0x020, immediate=0.
REQ-032 SHALL cover: addi x1,x0,-1 (0xFFF00093), XLEN=64 -> ctrl_signal=0x030, immediate=0xFFFFFFFFFFFFFFFF.
REQ-033 SHALL cover: bne with imm -4 (0xFE209EE3) -> ctrl_signal=0x209, immediate=-4 sign-extended.
REQ-034 SHALL cover: out_ready=0 with three back-to-back pushes -> in_ready falls after second accept, third held; release out_ready -> order preserved.
REQ-035 SHALL cover: rst_n=0 while FULL -> next cycle out_valid=0, in_ready=1, all outputs 0.
REQ-036 SHALL cover: word 0xFFFFFFFF with DECODE_ILLEGAL_TRAP_EN -> illegal=1, ctrl_signal=0; without macro -> illegal=0, ctrl_signal=0.
